execute_mult_writeback: RTL

EXECUTE_MULT_WRITEBACK -- requirements
Module: execute_mult_writeback

---
 rtl/execute_mult_writeback.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/execute_mult_writeback.sv
// Writeback sequencer for MUL/IMUL/AAD: waits for the multiplier product, writes EAX (and EDX for
// wide products) through a valid/ready port, then reports flags for one cycle.
module execute_mult_writeback #(
  parameter int RESULT_W = 66
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exe_reset,
  input  logic                start,
  input  logic                cmd_imul,
  input  logic                cmd_aad,
  input  logic                is_8bit,
  input  logic                operand_16bit,
  input  logic                operand_32bit,
  input  logic [7:0]          al_in,
  input  logic [RESULT_W-1:0] mult_result,
  input  logic                mult_busy,
  input  logic                mult_overflow,
  output logic                wr_valid,
  input  logic                wr_ready,
  output logic [2:0]          wr_reg,
  output logic [1:0]          wr_size,
  output logic [31:0]         wr_data,
  output logic                flags_valid,
  output logic                cf,
  output logic                of,
  output logic                sf,
  output logic                zf,
  output logic                pf,
  output logic                busy,
  output logic                done,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_WR_LO = 3'd2,
    S_WR_HI = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_aad;
  logic        r_is16;
  logic        r_is32;
  logic        r_ovf;
  logic [7:0]  r_al;
  logic [63:0] r_prod;

  logic        w_flush;
  logic        w_dual;
  logic [7:0]  w_sum;
  logic        w_unused;

  assign w_flush   = rst | exe_reset;
  assign w_dual    = !r_aad && (r_is16 || r_is32);
  assign w_sum     = r_al + r_prod[7:0];
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;
  // Signedness is already resolved by the multiplier; only the low 64 product bits are written.
  assign w_unused  = ^{cmd_imul, is_8bit, mult_result[RESULT_W-1:64]};

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_state <= S_IDLE;
      r_aad   <= 1'b0;
      r_is16  <= 1'b0;
      r_is32  <= 1'b0;
      r_ovf   <= 1'b0;
      r_al    <= 8'h00;
      r_prod  <= 64'h0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_aad  <= cmd_aad;
        r_is16 <= operand_16bit;
        r_is32 <= operand_32bit;
        r_al   <= al_in;
      end
      if (r_state == S_WAIT && !mult_busy) begin
        r_prod <= mult_result[63:0];
        r_ovf  <= mult_overflow;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_WAIT;
      S_WAIT:  if (!mult_busy) w_next = S_WR_LO;
      S_WR_LO: if (wr_ready) w_next = w_dual ? S_WR_HI : S_DONE;
      S_WR_HI: if (wr_ready) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Write port: valid/ready handshake; a beat transfers on a rising edge where wr_valid and
  // wr_ready are both high, and reg/size/data stay constant while wr_valid waits for wr_ready.
  always_comb begin
    wr_valid = 1'b0;
    wr_reg   = 3'd0;
    wr_size  = 2'd0;
    wr_data  = 32'h0;
    case (r_state)
      S_WR_LO: begin
        wr_valid = 1'b1;
        wr_reg   = 3'd0;
        if (r_aad) begin
          wr_size = 2'd1;
          wr_data = {24'h0, w_sum};
        end else if (r_is32) begin
          wr_size = 2'd2;
          wr_data = r_prod[31:0];
        end else begin
          wr_size = 2'd1;
          wr_data = {16'h0, r_prod[15:0]};
        end
      end
      S_WR_HI: begin
        wr_valid = 1'b1;
        wr_reg   = 3'd2;
        if (r_is32) begin
          wr_size = 2'd2;
          wr_data = r_prod[63:32];
        end else begin
          wr_size = 2'd1;
          wr_data = {16'h0, r_prod[31:16]};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    done        = 1'b0;
    flags_valid = 1'b0;
    cf          = 1'b0;
    of          = 1'b0;
    sf          = 1'b0;
    zf          = 1'b0;
    pf          = 1'b0;
    if (r_state == S_DONE) begin
      done        = 1'b1;
      flags_valid = 1'b1;
      if (r_aad) begin
        sf = w_sum[7];
        zf = (w_sum == 8'h00);
        pf = ~^w_sum;
      end else begin
        cf = r_ovf;
        of = r_ovf;
        pf = ~^r_prod[7:0];
        if (r_is32) begin
          sf = r_prod[31];
          zf = (r_prod[31:0] == 32'h0);
        end else if (r_is16) begin
          sf = r_prod[15];
          zf = (r_prod[15:0] == 16'h0);
        end else begin
          sf = r_prod[7];
          zf = (r_prod[7:0] == 8'h00);
        end
      end
    end
  end

endmodule
